// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through or registered read,
// programmable almost-full/almost-empty thresholds, synchronous flush, sticky
// overflow/underflow flags and exact fill-level / free-space outputs.
module sync_fifo_fwft #(
  parameter int W    = 8,
  parameter int DP   = 16,
  parameter bit FWFT = 1'b1,
  parameter int AW   = $clog2(DP)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  input  logic          flush,
  input  logic [AW:0]   cfg_afull_th,
  input  logic [AW:0]   cfg_aempty_th,
  input  logic          clr_err,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   level,
  output logic [AW:0]   free_space,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DEPTH = (AW+1)'(DP);

  logic [W-1:0]  mem_q [DP];

  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [AW:0]   level_q,     level_d;
  logic [W-1:0]  rd_data_q,   rd_data_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic          rd_acc;
  logic          wr_acc;
  logic          rd_do;
  logic          wr_do;
  logic [W-1:0]  head_data;

  // Status flags and acceptance decisions, all derived from registered level.
  always_comb begin
    empty      = (level_q == '0);
    full       = (level_q == DEPTH);
    afull      = (cfg_afull_th != '0) && (level_q >= cfg_afull_th);
    aempty     = (level_q <= cfg_aempty_th);
    free_space = DEPTH - level_q;
    level      = level_q;
    overflow   = overflow_q;
    underflow  = underflow_q;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
    // Flush overrides both requests: nothing is stored or popped that cycle.
    wr_do  = wr_acc && !flush;
    rd_do  = rd_acc && !flush;

    head_data = empty ? '0 : mem_q[rd_ptr_q];
    rd_data   = FWFT ? head_data : rd_data_q;
  end

  // Next-state for pointers, level, registered read data and error flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_do) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_do) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_do, rd_do})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end

    // Clear first, then a same-cycle error re-sets the flag (set wins).
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && !wr_acc && !flush) overflow_d  = 1'b1;
    if (rd_en && empty && !flush)   underflow_d = 1'b1;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; the pointers and level define validity.
    if (wr_do) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: a FWFT and a registered-read instance
// (DP=4, W=8) share one stimulus stream so both read modes are checked together.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en, rd_en, flush, clr_err;
  logic [7:0] wr_data;
  logic [2:0] cfg_afull_th, cfg_aempty_th;

  logic [7:0] f_rd_data, r_rd_data;
  logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic       r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic [2:0] f_level, f_free, r_level, r_free;

  int checks   = 0;
  int failures = 0;

  sync_fifo_fwft #(.W(8), .DP(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .flush(flush), .cfg_afull_th(cfg_afull_th),
    .cfg_aempty_th(cfg_aempty_th), .clr_err(clr_err), .full(f_full), .empty(f_empty),
    .afull(f_afull), .aempty(f_aempty), .level(f_level), .free_space(f_free),
    .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo_fwft #(.W(8), .DP(4), .FWFT(1'b0)) u_reg (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .flush(flush), .cfg_afull_th(cfg_afull_th),
    .cfg_aempty_th(cfg_aempty_th), .clr_err(clr_err), .full(r_full), .empty(r_empty),
    .afull(r_afull), .aempty(r_aempty), .level(r_level), .free_space(r_free),
    .overflow(r_ovf), .underflow(r_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       fl;
    logic       ce;
    int         lvl;   // expected level after the edge
    logic [7:0] rf;    // expected FWFT rd_data
    logic [7:0] rr;    // expected registered rd_data
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [7:0] wd, logic rd, logic fl, logic ce,
                              int lvl, logic [7:0] rf, logic [7:0] rr, logic ov, logic un);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.fl = fl; v.ce = ce;
    v.lvl = lvl; v.rf = rf; v.rr = rr; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
  endtask

  // Compare both instances' status against the expected level and thresholds.
  task automatic check_status(input string tag, input int lvl);
    logic exp_afull, exp_aempty;
    exp_afull  = (cfg_afull_th != 0) && (lvl >= int'(cfg_afull_th));
    exp_aempty = (lvl <= int'(cfg_aempty_th));
    check({tag, "_level"},  32'(f_level), 32'(lvl));
    check({tag, "_rlevel"}, 32'(r_level), 32'(lvl));
    check({tag, "_empty"},  32'(f_empty), 32'(lvl == 0));
    check({tag, "_full"},   32'(f_full),  32'(lvl == 4));
    check({tag, "_free"},   32'(f_free),  32'(4 - lvl));
    check({tag, "_afull"},  32'(f_afull), 32'(exp_afull));
    check({tag, "_aempty"}, 32'(f_aempty), 32'(exp_aempty));
  endtask

  initial begin
    idle();
    cfg_afull_th  = 3'd3;
    cfg_aempty_th = 3'd1;
    reset_n = 1'b0;
    #12;
    check_status("rst", 0);
    check("rst_rd_fwft", 32'(f_rd_data), 32'h0);
    check("rst_rd_reg",  32'(r_rd_data), 32'h0);
    check("rst_ovf", 32'(f_ovf | r_ovf), 32'h0);
    check("rst_unf", 32'(f_unf | r_unf), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill/drain, underflow/clear, full read+write, overflow, flush, reuse after flush.
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 1, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 2, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 3, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h44, 0, 0, 0, 4, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 3, 8'h22, 8'h11, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 2, 8'h33, 8'h22, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'h44, 8'h33, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h44, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h44, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h44, 0, 0));
    vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 8'hA5, 8'h44, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 8'hA5, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 1, 8'h01, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 0, 2, 8'h01, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 3, 8'h01, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0, 4, 8'h01, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 8'h55, 1, 0, 0, 4, 8'h02, 8'h01, 0, 0));
    vecs.push_back(mk(1, 8'h66, 0, 0, 0, 4, 8'h02, 8'h01, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 3, 8'h03, 8'h02, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 2, 8'h04, 8'h03, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'h55, 8'h04, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h55, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h55, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h55, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'h77, 0, 0, 0, 1, 8'h77, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'h88, 0, 0, 0, 2, 8'h77, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'h99, 0, 0, 0, 3, 8'h77, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 1, 1, 0, 0, 8'h00, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'hBB, 0, 0, 0, 1, 8'hBB, 8'h55, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      wr_en = vecs[i].wr; wr_data = vecs[i].wd; rd_en = vecs[i].rd;
      flush = vecs[i].fl; clr_err = vecs[i].ce;
      step();
      check_status(tag, vecs[i].lvl);
      check({tag, "_rd_fwft"}, 32'(f_rd_data), 32'(vecs[i].rf));
      check({tag, "_rd_reg"},  32'(r_rd_data), 32'(vecs[i].rr));
      check({tag, "_ovf"},  32'(f_ovf), 32'(vecs[i].ov));
      check({tag, "_rovf"}, 32'(r_ovf), 32'(vecs[i].ov));
      check({tag, "_unf"},  32'(f_unf), 32'(vecs[i].un));
      check({tag, "_runf"}, 32'(r_unf), 32'(vecs[i].un));
    end

    // Thresholds: afull disabled at every level, and a threshold change acts at once.
    idle();
    flush = 1'b1; step(); idle();
    cfg_afull_th = 3'd0;
    for (int k = 0; k <= 4; k++) begin
      check($sformatf("th0_afull_l%0d", k), 32'(f_afull), 32'h0);
      check($sformatf("th_aempty_l%0d", k), 32'(f_aempty), 32'(k <= 1));
      cfg_afull_th = 3'd3; #1;
      check($sformatf("th3_afull_l%0d", k), 32'(f_afull), 32'(k >= 3));
      cfg_afull_th = 3'd0; #1;
      if (k < 4) begin
        wr_en = 1'b1; wr_data = 8'(k); step(); idle();
      end
    end
    cfg_afull_th = 3'd3;
    for (int k = 3; k >= 0; k--) begin
      rd_en = 1'b1; step(); idle();
      check_status($sformatf("drain_l%0d", k), k);
    end

    // Streaming with pointer wrap, then asynchronous reset mid-stream.
    wr_en = 1'b1; wr_data = 8'h30; step();
    for (int i = 1; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h30 + i);
      step();
      check($sformatf("strm%0d_fwft", i), 32'(f_rd_data), 32'(8'h30 + i));
      check($sformatf("strm%0d_reg", i),  32'(r_rd_data), 32'(8'h30 + i - 1));
      check($sformatf("strm%0d_level", i), 32'(f_level), 32'h1);
      if (i == 12) begin
        #2 reset_n = 1'b0;
        #1;
        check_status("arst", 0);
        check("arst_rd_fwft", 32'(f_rd_data), 32'h0);
        check("arst_rd_reg",  32'(r_rd_data), 32'h0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        wr_en = 1'b1; wr_data = 8'hC3; step(); idle();
        check("post_rst_fwft", 32'(f_rd_data), 32'hC3);
        check_status("post_rst", 1);
        break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
